// File: rtl/rob_tid_alloc_pkg.sv
// Shared widths and FSM state type for the reorder-buffer transaction-ID allocator.
package rob_tid_alloc_pkg;

  localparam int AXI_ID_WIDTH   = 4;
  localparam int AXI_ADDR_WIDTH = 32;
  localparam int DEF_TID_WIDTH  = 3;
  localparam int FIFO_SIZE      = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ISSUE = 1'b1
  } state_t;

endpackage

// File: rtl/rob_tid_alloc_if.sv
// Bundle of the AR intake, tag-compare request, retire and status signals of rob_tid_alloc.
interface rob_tid_alloc_if
  import rob_tid_alloc_pkg::*;
#(
  parameter int ID_WIDTH   = AXI_ID_WIDTH,
  parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
  parameter int TID_WIDTH  = DEF_TID_WIDTH
);

  logic                  ar_valid_i;
  logic                  ar_ready_o;
  logic [ID_WIDTH-1:0]   ar_id_i;
  logic [ADDR_WIDTH-1:0] ar_addr_i;

  logic                  req_valid_o;
  logic                  req_ready_i;
  logic [TID_WIDTH-1:0]  req_tid_o;
  logic [ADDR_WIDTH-1:0] req_addr_o;

  logic                  retire_i;
  logic [TID_WIDTH-1:0]  retire_tid_i;
  logic [ID_WIDTH-1:0]   retire_rid_o;

  logic [TID_WIDTH:0]    outstanding_o;
  logic                  idle_o;
  logic                  err_o;

  modport slave (
    input  ar_valid_i, ar_id_i, ar_addr_i, req_ready_i, retire_i, retire_tid_i,
    output ar_ready_o, req_valid_o, req_tid_o, req_addr_o, retire_rid_o,
           outstanding_o, idle_o, err_o
  );

  modport master (
    output ar_valid_i, ar_id_i, ar_addr_i, req_ready_i, retire_i, retire_tid_i,
    input  ar_ready_o, req_valid_o, req_tid_o, req_addr_o, retire_rid_o,
           outstanding_o, idle_o, err_o
  );

endinterface

// File: rtl/rob_tid_alloc_rid_table.sv
// tID-indexed table of AXI read IDs: one synchronous write port, one asynchronous read port.
module rob_rid_table #(
  parameter int TID_WIDTH = 3,
  parameter int ID_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [TID_WIDTH-1:0] waddr,
  input  logic [ID_WIDTH-1:0]  wdata,
  input  logic [TID_WIDTH-1:0] raddr,
  output logic [ID_WIDTH-1:0]  rdata
);

  logic [ID_WIDTH-1:0] mem [2**TID_WIDTH];

  // Contents survive reset; a stale entry is only read after it has been rewritten.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rob_tid_alloc.sv
// Assigns rolling transaction IDs to AXI read requests and tracks them until the reorder buffer retires them.
module rob_tid_alloc
  import rob_tid_alloc_pkg::*;
#(
  parameter int ID_WIDTH        = AXI_ID_WIDTH,
  parameter int ADDR_WIDTH      = AXI_ADDR_WIDTH,
  parameter int TID_WIDTH       = DEF_TID_WIDTH,
  parameter int MAX_OUTSTANDING = FIFO_SIZE
) (
  input logic            clk,
  input logic            rst_n,
  rob_tid_alloc_if.slave bus
);

  localparam logic [TID_WIDTH:0]   MAX_CNT = (TID_WIDTH+1)'(MAX_OUTSTANDING);
  localparam logic [TID_WIDTH:0]   CNT_ONE = (TID_WIDTH+1)'(1);
  localparam logic [TID_WIDTH-1:0] TID_ONE = TID_WIDTH'(1);

  state_t                state_q;
  state_t                state_d;
  logic [TID_WIDTH-1:0]  alloc_tid;
  logic [TID_WIDTH-1:0]  retire_ptr;
  logic [TID_WIDTH-1:0]  req_tid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [TID_WIDTH:0]    outstanding;
  logic                  err;
  logic                  ar_ready;
  logic                  accept;
  logic                  retire_ok;
  logic                  retire_underflow;
  logic                  retire_mismatch;

  // Held low while rst_n is asserted so nothing is accepted before the state is known.
  assign ar_ready         = rst_n && (state_q == S_IDLE) && (outstanding < MAX_CNT);
  assign accept           = bus.ar_valid_i && ar_ready;
  assign retire_ok        = bus.retire_i && (outstanding != '0);
  assign retire_underflow = bus.retire_i && (outstanding == '0);
  assign retire_mismatch  = retire_ok && (bus.retire_tid_i != retire_ptr);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)          state_d = S_ISSUE;
      S_ISSUE: if (bus.req_ready_i) state_d = S_IDLE;
      default:                      state_d = S_IDLE;
    endcase
  end

  // A mismatched retire still advances the pointer so later retires are judged against the expected order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alloc_tid   <= TID_ONE;
      retire_ptr  <= TID_ONE;
      outstanding <= '0;
      err         <= 1'b0;
      req_tid     <= '0;
      req_addr    <= '0;
    end else begin
      if (accept) begin
        req_tid   <= alloc_tid;
        req_addr  <= bus.ar_addr_i;
        alloc_tid <= alloc_tid + TID_ONE;
      end
      if (retire_ok) retire_ptr <= retire_ptr + TID_ONE;
      case ({accept, retire_ok})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase
      if (retire_underflow || retire_mismatch) err <= 1'b1;
    end
  end

  rob_rid_table #(
    .TID_WIDTH(TID_WIDTH),
    .ID_WIDTH (ID_WIDTH)
  ) u_rid_table (
    .clk  (clk),
    .we   (accept),
    .waddr(alloc_tid),
    .wdata(bus.ar_id_i),
    .raddr(bus.retire_tid_i),
    .rdata(bus.retire_rid_o)
  );

  assign bus.ar_ready_o    = ar_ready;
  assign bus.req_valid_o   = (state_q == S_ISSUE);
  assign bus.req_tid_o     = req_tid;
  assign bus.req_addr_o    = req_addr;
  assign bus.outstanding_o = outstanding;
  assign bus.idle_o        = (outstanding == '0) && (state_q == S_IDLE);
  assign bus.err_o         = err;

endmodule

// File: tb/tb_rob_tid_alloc.sv
// Directed self-checking bench for rob_tid_alloc with TID_WIDTH=3 and MAX_OUTSTANDING=4.
module tb_rob_tid_alloc;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  rob_tid_alloc_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .TID_WIDTH(3)) bus ();

  rob_tid_alloc #(
    .ID_WIDTH       (4),
    .ADDR_WIDTH     (32),
    .TID_WIDTH      (3),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n           = 1'b0;
    bus.ar_valid_i  = 1'b0;
    bus.retire_i    = 1'b0;
    bus.req_ready_i = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Waits (bounded) for ar_ready, completes the AR handshake, checks the request, then lets it drain.
  task automatic apply_stimulus(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] exp_tid);
    int waited = 0;
    bus.ar_valid_i = 1'b1;
    bus.ar_id_i    = id;
    bus.ar_addr_i  = addr;
    #1;
    while (!bus.ar_ready_o && waited < 20) begin
      tick();
      waited++;
    end
    check_output("ar_ready_wait", 32'(waited < 20), 32'd1);
    tick();
    bus.ar_valid_i = 1'b0;
    check_output("issue_req_valid", 32'(bus.req_valid_o), 32'd1);
    check_output("issue_req_tid", 32'(bus.req_tid_o), 32'(exp_tid));
    check_output("issue_req_addr", bus.req_addr_o, addr);
    tick();
  endtask

  task automatic do_retire(input logic [2:0] tid, input logic [3:0] exp_rid);
    bus.retire_i     = 1'b1;
    bus.retire_tid_i = tid;
    #1;
    check_output("retire_rid", 32'(bus.retire_rid_o), 32'(exp_rid));
    tick();
    bus.retire_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n            = 1'b0;
    bus.ar_valid_i   = 1'b0;
    bus.ar_id_i      = '0;
    bus.ar_addr_i    = '0;
    bus.req_ready_i  = 1'b1;
    bus.retire_i     = 1'b0;
    bus.retire_tid_i = '0;
    tick();
    tick();

    check_output("rst_ar_ready", 32'(bus.ar_ready_o), 32'd0);
    check_output("rst_req_valid", 32'(bus.req_valid_o), 32'd0);
    check_output("rst_req_tid", 32'(bus.req_tid_o), 32'd0);
    check_output("rst_req_addr", bus.req_addr_o, 32'd0);
    check_output("rst_outstanding", 32'(bus.outstanding_o), 32'd0);
    check_output("rst_err", 32'(bus.err_o), 32'd0);
    rst_n = 1'b1;
    tick();
    check_output("release_ar_ready", 32'(bus.ar_ready_o), 32'd1);
    check_output("release_idle", 32'(bus.idle_o), 32'd1);

    // Single request: latency one, first tID is 1.
    bus.ar_valid_i = 1'b1;
    bus.ar_id_i    = 4'h3;
    bus.ar_addr_i  = 32'h100;
    #1;
    check_output("t1_ar_ready", 32'(bus.ar_ready_o), 32'd1);
    tick();
    bus.ar_valid_i = 1'b0;
    check_output("t1_req_valid", 32'(bus.req_valid_o), 32'd1);
    check_output("t1_req_tid", 32'(bus.req_tid_o), 32'd1);
    check_output("t1_req_addr", bus.req_addr_o, 32'h100);
    check_output("t1_outstanding", 32'(bus.outstanding_o), 32'd1);
    check_output("t1_busy_ar_ready", 32'(bus.ar_ready_o), 32'd0);
    tick();
    check_output("t1_req_valid_drop", 32'(bus.req_valid_o), 32'd0);
    check_output("t1_ar_ready_back", 32'(bus.ar_ready_o), 32'd1);
    do_retire(3'd1, 4'h3);
    check_output("t1_outstanding_zero", 32'(bus.outstanding_o), 32'd0);
    check_output("t1_idle", 32'(bus.idle_o), 32'd1);

    // Stalled tag-compare stage: request must hold steady while a competing AR waits.
    bus.req_ready_i = 1'b0;
    bus.ar_valid_i  = 1'b1;
    bus.ar_id_i     = 4'h7;
    bus.ar_addr_i   = 32'h2A0;
    tick();
    bus.ar_id_i   = 4'h9;
    bus.ar_addr_i = 32'h999;
    for (int i = 0; i < 3; i++) begin
      check_output("stall_req_valid", 32'(bus.req_valid_o), 32'd1);
      check_output("stall_req_tid", 32'(bus.req_tid_o), 32'd2);
      check_output("stall_req_addr", bus.req_addr_o, 32'h2A0);
      check_output("stall_ar_ready", 32'(bus.ar_ready_o), 32'd0);
      tick();
    end
    bus.ar_valid_i  = 1'b0;
    bus.req_ready_i = 1'b1;
    check_output("stall_req_valid_end", 32'(bus.req_valid_o), 32'd1);
    tick();
    check_output("stall_req_valid_drop", 32'(bus.req_valid_o), 32'd0);
    check_output("stall_outstanding", 32'(bus.outstanding_o), 32'd1);
    do_retire(3'd2, 4'h7);

    // Reset while a request is held discards it.
    bus.req_ready_i = 1'b0;
    bus.ar_valid_i  = 1'b1;
    bus.ar_id_i     = 4'h5;
    bus.ar_addr_i   = 32'h55;
    tick();
    bus.ar_valid_i = 1'b0;
    check_output("midrst_pre_valid", 32'(bus.req_valid_o), 32'd1);
    rst_n = 1'b0;
    tick();
    check_output("midrst_req_valid", 32'(bus.req_valid_o), 32'd0);
    check_output("midrst_outstanding", 32'(bus.outstanding_o), 32'd0);
    check_output("midrst_req_tid", 32'(bus.req_tid_o), 32'd0);
    check_output("midrst_ar_ready", 32'(bus.ar_ready_o), 32'd0);
    rst_n           = 1'b1;
    bus.req_ready_i = 1'b1;
    tick();
    check_output("midrst_idle", 32'(bus.idle_o), 32'd1);

    // Fill to the credit limit, reopen with one retire, then drain in order.
    for (int i = 1; i <= 4; i++) apply_stimulus(4'(i), 32'h1000 + 32'(i * 16), 3'(i));
    check_output("full_outstanding", 32'(bus.outstanding_o), 32'd4);
    check_output("full_ar_ready", 32'(bus.ar_ready_o), 32'd0);
    check_output("full_idle", 32'(bus.idle_o), 32'd0);
    tick();
    check_output("full_ar_ready_hold", 32'(bus.ar_ready_o), 32'd0);
    bus.retire_i     = 1'b1;
    bus.retire_tid_i = 3'd1;
    bus.ar_valid_i   = 1'b1;
    bus.ar_id_i      = 4'h5;
    bus.ar_addr_i    = 32'h1050;
    #1;
    check_output("full_retire_rid", 32'(bus.retire_rid_o), 32'h1);
    check_output("full_ready_same_cycle", 32'(bus.ar_ready_o), 32'd0);
    tick();
    bus.retire_i = 1'b0;
    check_output("full_ready_reopen", 32'(bus.ar_ready_o), 32'd1);
    tick();
    bus.ar_valid_i = 1'b0;
    check_output("fifth_req_tid", 32'(bus.req_tid_o), 32'd5);
    check_output("fifth_req_addr", bus.req_addr_o, 32'h1050);
    check_output("fifth_outstanding", 32'(bus.outstanding_o), 32'd4);
    tick();
    for (int i = 2; i <= 5; i++) do_retire(3'(i), 4'(i));
    check_output("drain_outstanding", 32'(bus.outstanding_o), 32'd0);
    check_output("drain_idle", 32'(bus.idle_o), 32'd1);
    check_output("drain_err", 32'(bus.err_o), 32'd0);

    // Nine issue/retire pairs wrap the 3-bit tID: 1..7, 0, 1.
    apply_reset();
    for (int k = 0; k < 9; k++) begin
      apply_stimulus(4'(k + 1), 32'h2000 + 32'(k * 4), 3'((k + 1) % 8));
      do_retire(3'((k + 1) % 8), 4'(k + 1));
    end
    check_output("wrap_err", 32'(bus.err_o), 32'd0);
    check_output("wrap_outstanding", 32'(bus.outstanding_o), 32'd0);

    // Retire with nothing outstanding is ignored but flagged, and the flag sticks.
    bus.retire_i     = 1'b1;
    bus.retire_tid_i = 3'd2;
    tick();
    bus.retire_i = 1'b0;
    check_output("uf_err", 32'(bus.err_o), 32'd1);
    check_output("uf_outstanding", 32'(bus.outstanding_o), 32'd0);
    tick();
    check_output("uf_err_sticky", 32'(bus.err_o), 32'd1);

    apply_reset();
    check_output("rst_clears_err", 32'(bus.err_o), 32'd0);
    apply_stimulus(4'h6, 32'h300, 3'd1);

    // Acceptance and retire on the same edge leave the count unchanged.
    bus.ar_valid_i   = 1'b1;
    bus.ar_id_i      = 4'hC;
    bus.ar_addr_i    = 32'h310;
    bus.retire_i     = 1'b1;
    bus.retire_tid_i = 3'd1;
    #1;
    check_output("sim_retire_rid", 32'(bus.retire_rid_o), 32'h6);
    tick();
    bus.ar_valid_i = 1'b0;
    bus.retire_i   = 1'b0;
    check_output("sim_outstanding", 32'(bus.outstanding_o), 32'd1);
    check_output("sim_req_tid", 32'(bus.req_tid_o), 32'd2);
    check_output("sim_err", 32'(bus.err_o), 32'd0);
    tick();

    // Out-of-order retire (tid 3 while pointer is 2) flags an error but still retires.
    bus.retire_i     = 1'b1;
    bus.retire_tid_i = 3'd3;
    tick();
    bus.retire_i = 1'b0;
    check_output("mm_err", 32'(bus.err_o), 32'd1);
    check_output("mm_outstanding", 32'(bus.outstanding_o), 32'd0);
    apply_stimulus(4'hD, 32'h320, 3'd3);
    do_retire(3'd3, 4'hD);
    check_output("mm_err_sticky", 32'(bus.err_o), 32'd1);
    apply_reset();
    check_output("mm_err_reset", 32'(bus.err_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
